// File: rtl/ahb_cmd_master.sv
// Command-to-AHB-Lite master bridge. It issues single transfers only, using a
// two-stage pipeline: stage A holds the address phase and stage D holds the
// data phase. Responses return in acceptance order.
module ahb_cmd_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [1:0]            cmd_size,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic [1:0]            hsize,
   output logic                  hwrite,
   output logic [2:0]            hburst,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   input  logic                  hresp,
   input  logic [DATA_WIDTH-1:0] hrdata
);

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;

   // StErrIdle is the second ERROR cycle: the bus shows IDLE and stage A is held.
   typedef enum logic {StNormal, StErrIdle} state_e;

   state_e                state_q, state_d;
   logic                  rdy_en_q, rdy_en_d;
   logic                  a_valid_q, a_valid_d;
   logic                  a_write_q, a_write_d;
   logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
   logic [1:0]            a_size_q, a_size_d;
   logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
   logic                  d_valid_q, d_valid_d;
   logic                  d_write_q, d_write_d;
   logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;

   logic [1:0]            size_norm;
   logic [ADDR_WIDTH-1:0] addr_aligned;
   logic                  err_first;
   logic                  a_adv;
   logic                  accept;

   // Normalise the command size (3 behaves as word) and align the address to it.
   always_comb begin
      size_norm    = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
      addr_aligned = cmd_addr;
      if (size_norm == 2'd1) addr_aligned[0] = 1'b0;
      if (size_norm == 2'd2) addr_aligned[1:0] = 2'b00;
   end

   // Pipeline control, the error sequencer and the next state of both stages.
   always_comb begin
      err_first = d_valid_q & hresp & ~hready;
      // A advances only when its address phase was really on the bus, i.e. not
      // during the forced IDLE cycle.
      a_adv     = a_valid_q & hready & (state_q == StNormal);
      // a_adv implies hready=1, so it already excludes the first ERROR cycle.
      cmd_ready = rdy_en_q & (~a_valid_q | a_adv);
      accept    = cmd_valid & cmd_ready;

      rdy_en_d  = 1'b1;
      state_d   = state_q;
      a_valid_d = a_valid_q;
      a_write_d = a_write_q;
      a_addr_d  = a_addr_q;
      a_size_d  = a_size_q;
      a_wdata_d = a_wdata_q;
      d_valid_d = d_valid_q;
      d_write_d = d_write_q;
      d_wdata_d = d_wdata_q;

      unique case (state_q)
         StNormal:  if (err_first) state_d = StErrIdle;
         StErrIdle: if (hready)    state_d = StNormal;
         default:   state_d = StNormal;
      endcase

      if (accept) begin
         a_valid_d = 1'b1;
         a_write_d = cmd_write;
         a_addr_d  = addr_aligned;
         a_size_d  = size_norm;
         a_wdata_d = cmd_wdata;
      end else if (a_adv) begin
         a_valid_d = 1'b0;
      end

      if (hready) begin
         d_valid_d = a_adv;
         d_write_d = a_write_q;
         d_wdata_d = a_wdata_q;
      end
   end

   // Bus and response outputs, all derived from the stage registers.
   always_comb begin
      htrans    = (a_valid_q && state_q == StNormal) ? HtransNonseq : HtransIdle;
      haddr     = a_valid_q ? a_addr_q : '0;
      hsize     = a_valid_q ? a_size_q : 2'd0;
      hwrite    = a_valid_q & a_write_q;
      hburst    = 3'b000;
      hwdata    = (d_valid_q && d_write_q) ? d_wdata_q : '0;
      rsp_valid = d_valid_q & hready;
      rsp_err   = rsp_valid & hresp;
      rsp_rdata = (rsp_valid && !d_write_q) ? hrdata : '0;
   end

   // State registers; reset discards both stages.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= StNormal;
         rdy_en_q  <= 1'b0;
         a_valid_q <= 1'b0;
         a_write_q <= 1'b0;
         a_addr_q  <= '0;
         a_size_q  <= 2'd0;
         a_wdata_q <= '0;
         d_valid_q <= 1'b0;
         d_write_q <= 1'b0;
         d_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         rdy_en_q  <= rdy_en_d;
         a_valid_q <= a_valid_d;
         a_write_q <= a_write_d;
         a_addr_q  <= a_addr_d;
         a_size_q  <= a_size_d;
         a_wdata_q <= a_wdata_d;
         d_valid_q <= d_valid_d;
         d_write_q <= d_write_d;
         d_wdata_q <= d_wdata_d;
      end
   end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: it runs a table of commands against a behavioural
// AHB slave, whose wait states and ERROR responses are keyed by address, and
// scoreboards the address phases and the responses.
module tb_ahb_cmd_master;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [1:0]  cmd_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans, hsize;
   logic        hwrite, hready, hresp;
   logic [2:0]  hburst;

   int checks = 0;
   int errors = 0;

   ahb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .hclk(hclk), .hresetn(hresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
      .hburst(hburst), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_haddr;
      logic [1:0]  exp_hsize;
   } vec_t;

   typedef struct {
      logic [31:0] haddr;
      logic [1:0]  hsize;
      logic        hwrite;
      logic [31:0] wdata;
   } aexp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rexp_t;

   aexp_t aq[$];
   rexp_t rq[$];

   // Slave behaviour keyed by the aligned address.
   function automatic int waits_of(input logic [31:0] a);
      return (a == 32'h8) ? 3 : int'(a[9:8]);
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return (a == 32'h20) || a[12];
   endfunction

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave data-phase state and monitor history.
   logic        dp_v = 1'b0, dp_write = 1'b0;
   logic [31:0] dp_addr = '0, dp_wdata = '0;
   int          cnt = 0;
   logic        p_err1 = 1'b0, p_hold = 1'b0, p_hwhold = 1'b0;
   logic [31:0] p_haddr = '0, p_hwdata = '0;

   // Slave driver (posedge + 1) and bus/response monitor (negedge).
   initial begin
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      forever begin
         @(posedge hclk); #1;
         hresp  = 1'b0;
         hready = 1'b1;
         hrdata = 32'hFFFF_0000;
         if (hresetn && dp_v) begin
            if (cnt < waits_of(dp_addr)) begin
               hready = 1'b0;
            end else if (err_of(dp_addr)) begin
               hresp  = 1'b1;
               hready = (cnt != waits_of(dp_addr));
            end
            if (hready) hrdata = rd_of(dp_addr);
         end
         @(negedge hclk);
         if (!hresetn) begin
            aq.delete(); rq.delete();
            dp_v = 1'b0; p_err1 = 1'b0; p_hold = 1'b0; p_hwhold = 1'b0;
         end else begin
            chk("htrans_legal", 32'(htrans == 2'b00 || htrans == 2'b10), 32'd1);
            chk("hburst", 32'(hburst), 32'd0);
            if (p_err1) chk("htrans_idle_after_err", 32'(htrans), 32'd0);
            if (p_hold) begin
               chk("haddr_held", haddr, p_haddr);
               chk("htrans_held", 32'(htrans), 32'd2);
            end
            if (p_hwhold) chk("hwdata_held", hwdata, p_hwdata);
            chk("hwdata", hwdata, (dp_v && dp_write) ? dp_wdata : 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(dp_v && hready));
            if (dp_v && hready) begin
               if (rq.size() == 0) begin
                  chk("rsp_unexpected", 32'd1, 32'd0);
               end else begin
                  rexp_t r;
                  r = rq.pop_front();
                  chk("rsp_rdata", rsp_rdata, r.rdata);
                  chk("rsp_err", 32'(rsp_err), 32'(r.err));
               end
            end
            p_err1   = dp_v && hresp && !hready;
            p_hold   = !hready && htrans == 2'b10 && !p_err1;
            p_hwhold = !hready;
            p_haddr  = haddr;
            p_hwdata = hwdata;
            if (hready) begin
               cnt = 0;
               dp_v = 1'b0;
               if (htrans == 2'b10) begin
                  if (aq.size() == 0) begin
                     chk("nonseq_unexpected", 32'd1, 32'd0);
                  end else begin
                     aexp_t a;
                     a = aq.pop_front();
                     chk("haddr", haddr, a.haddr);
                     chk("hsize", 32'(hsize), 32'(a.hsize));
                     chk("hwrite", 32'(hwrite), 32'(a.hwrite));
                     dp_v = 1'b1; dp_addr = haddr; dp_write = hwrite; dp_wdata = a.wdata;
                  end
               end
            end else begin
               cnt++;
            end
         end
      end
   end

   // Present a command (caller is at posedge + 1); returns at posedge + 1 after acceptance.
   task automatic send(input vec_t v);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
      cmd_size = v.size; cmd_wdata = v.wdata;
      for (int n = 0; n < 50; n++) begin
         @(negedge hclk);
         if (cmd_ready) begin
            aq.push_back('{v.exp_haddr, v.exp_hsize, v.write, v.wdata});
            rq.push_back('{v.write ? 32'd0 : rd_of(v.exp_haddr), err_of(v.exp_haddr)});
            @(posedge hclk); #1;
            return;
         end
         @(posedge hclk); #1;
      end
      chk("cmd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         if (aq.size() == 0 && rq.size() == 0) return;
         @(posedge hclk); #1;
      end
      chk("drain_timeout", 32'(aq.size() + rq.size()), 32'd0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_htrans"}, 32'(htrans), 32'd0);
      chk({tag, "_haddr"}, haddr, 32'd0);
      chk({tag, "_hwrite"}, 32'(hwrite), 32'd0);
      chk({tag, "_hsize"}, 32'(hsize), 32'd0);
      chk({tag, "_hburst"}, 32'(hburst), 32'd0);
      chk({tag, "_hwdata"}, hwdata, 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   vec_t vecs[11];
   vec_t v;

   initial begin
      //               write  addr          size  wdata          exp_haddr     hsize
      vecs[0]  = '{1'b0, 32'h0000_0000, 2'd2, 32'h0,         32'h0000_0000, 2'd2};
      vecs[1]  = '{1'b0, 32'h0000_0004, 2'd2, 32'h0,         32'h0000_0004, 2'd2};
      vecs[2]  = '{1'b1, 32'h0000_0008, 2'd2, 32'hDEAD_BEEF, 32'h0000_0008, 2'd2};
      vecs[3]  = '{1'b0, 32'h0000_0020, 2'd2, 32'h0,         32'h0000_0020, 2'd2};
      vecs[4]  = '{1'b0, 32'h0000_0024, 2'd2, 32'h0,         32'h0000_0024, 2'd2};
      vecs[5]  = '{1'b0, 32'h0000_0013, 2'd1, 32'h0,         32'h0000_0012, 2'd1};
      vecs[6]  = '{1'b1, 32'h0000_0107, 2'd3, 32'h1234_5678, 32'h0000_0104, 2'd2};
      vecs[7]  = '{1'b0, 32'h0000_0203, 2'd0, 32'h0,         32'h0000_0203, 2'd0};
      vecs[8]  = '{1'b1, 32'h0000_1002, 2'd1, 32'hCAFE_F00D, 32'h0000_1002, 2'd1};
      vecs[9]  = '{1'b0, 32'h0000_1005, 2'd2, 32'h0,         32'h0000_1004, 2'd2};
      vecs[10] = '{1'b1, 32'h0000_0031, 2'd2, 32'h0BAD_CAFE, 32'h0000_0030, 2'd2};

      hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
      #3;
      chk_outputs_zero("reset");
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(negedge hclk);
      chk("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("cmd_ready_after_edge", 32'(cmd_ready), 32'd1);
      @(posedge hclk); #1;

      // Single write, cycle-exact.
      v = '{1'b1, 32'h10, 2'd2, 32'hA5A5_A5A5, 32'h10, 2'd2};
      send(v);
      cmd_valid = 1'b0;
      @(negedge hclk);
      chk("w10_htrans", 32'(htrans), 32'd2);
      chk("w10_haddr", haddr, 32'h10);
      @(negedge hclk);
      chk("w10_hwdata", hwdata, 32'hA5A5_A5A5);
      chk("w10_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("w10_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge hclk); #1;
      drain();

      // Table, back-to-back.
      for (int i = 0; i < 11; i++) send(vecs[i]);
      cmd_valid = 1'b0;
      drain();

      // Reset while a write sits in a waited data phase.
      v = '{1'b1, 32'h300, 2'd2, 32'h5555_AAAA, 32'h300, 2'd2};
      send(v);
      cmd_valid = 1'b0;
      @(posedge hclk); #3;
      chk("mid_hwdata_live", hwdata, 32'h5555_AAAA);
      hresetn = 1'b0;
      #1;
      chk_outputs_zero("mid_reset");
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(negedge hclk);
      chk("mid_cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge hclk); #1;
      v = '{1'b0, 32'h44, 2'd2, 32'h0, 32'h44, 2'd2};
      send(v);
      cmd_valid = 1'b0;
      drain();

      repeat (3) @(posedge hclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bit width of haddr and cmd_addr.
REQ-002 Parameter DATA_WIDTH, default 32, bit width of hwdata, hrdata, cmd_wdata and rsp_rdata.
REQ-003 hclk  in  1  bus clock; all state updates on the rising edge.
REQ-004 hresetn  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-009 cmd_size  in  2  transfer size: 0 = byte, 1 = half-word, 2 = word.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data.
REQ-013 rsp_err  out  1  transfer ended with an ERROR response.
REQ-014 haddr, htrans[1:0], hsize[1:0], hwrite, hburst[2:0], hwdata  out  AHB-Lite master outputs.
REQ-015 hready, hresp, hrdata  in  AHB-Lite slave responses (hready is the slave's hreadyout).

Function
REQ-016 The block SHALL issue single transfers only: hburst = 3'b000 always; htrans is 2'b10 (NONSEQ) or 2'b00 (IDLE).
REQ-017 The block SHALL run a two-stage pipeline (address phase A, data phase D); the A-phase of command N+1 overlaps the D-phase of command N.
REQ-018 cmd_ready SHALL be combinational: 1 when A is empty, or when hready=1 and no ERROR first cycle is present.
REQ-019 An accepted command SHALL drive haddr/hwrite/hsize with htrans=NONSEQ in the next cycle and hold them stable until a cycle with hready=1.
REQ-020 When hready=1 with A valid, A SHALL move to D; when hready=1 with D valid, D SHALL retire.
REQ-021 hwdata SHALL carry D's write data for the entire D-phase of a write; hwdata is 0 during reads and when idle.
REQ-022 On retire, rsp_valid SHALL pulse the same cycle with rsp_err=hresp; rsp_rdata=hrdata for reads and 0 for writes.
REQ-023 haddr SHALL be cmd_addr with low bits cleared to the size alignment (size 1: bit0; size 2: bits[1:0]); cmd_size=3 SHALL be treated as 2.
REQ-024 ERROR handling: in a cycle with hresp=1 and hready=0, the next cycle SHALL drive htrans=IDLE.
REQ-025 ERROR handling: during that ERROR sequence, the pending A command SHALL be held, not dropped.
REQ-026 ERROR handling: after the ERROR completes (hresp=1, hready=1), the held A command SHALL be re-issued as NONSEQ.
REQ-027 Response order SHALL equal acceptance order; at most 2 commands are outstanding.
REQ-028 With no valid A command, htrans SHALL be IDLE; IDLE cycles never produce rsp_valid.
REQ-029 Wait states (hready=0) of any length SHALL stall both stages with all outputs held.

Reset
REQ-030 While hresetn=0, outputs SHALL be 0: htrans, haddr, hwrite, hsize, hburst, hwdata, cmd_ready, rsp_valid, rsp_rdata and rsp_err.
REQ-031 The reset effect SHALL be immediate (asynchronous), with release synchronous to hclk; cmd_ready goes to 1 on the first edge after release.
REQ-032 Reset mid-transfer SHALL discard both stages with no rsp_valid for discarded commands.

Verification
REQ-033 Single write 0x10 data 0xA5A5A5A5 size 2, hready=1 -> NONSEQ haddr=0x10, next cycle hwdata=0xA5A5A5A5 with rsp_valid=1 and rsp_err=0.
REQ-034 Back-to-back read 0x0, read 0x4, zero waits -> haddr 0x0 then 0x4 on consecutive cycles; two rsp_valid pulses carrying hrdata in order.
REQ-035 Write 0x8 with 3 wait states (hready=0) -> haddr/hwdata held for 4 cycles; exactly one rsp_valid.
REQ-036 Read 0x20 gets ERROR while read 0x24 is in the A-phase -> htrans=IDLE in the second ERROR cycle, rsp_err=1 for 0x20, then 0x24 re-issued and completes with rsp_err=0.
REQ-037 Half-word read at address 0x13 -> haddr=0x12, hsize=1.
REQ-038 hresetn asserted during the D-phase of a write -> all outputs 0 immediately, no rsp_valid; after release the next command issues normally.
